// File: rtl/mesh_term_ingress.sv
// mesh_term_ingress: per-terminal source adapter; validates destinations, assembles mesh packets
// and buffers them in a show-ahead FIFO with a registered head toward the router.  Rev 1.0
`default_nettype none

module mesh_term_ingress #(
  parameter int          ROWS       = 4,
  parameter int          COLUMNS    = 4,
  parameter int          PCKG_SZ    = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [3:0]                      wr_row,
  input  logic [3:0]                      wr_col,
  input  logic                            wr_mode,
  input  logic [PCKG_SZ-18:0]             wr_payload,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            pndng_i_in,
  output logic [PCKG_SZ-1:0]              data_out_i_in,
  input  logic                            popin,
  input  logic                            clr_stat,
  output logic                            overflow,
  output logic [15:0]                     drop_cnt,
  output logic [15:0]                     illegal_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]      cnt, cnt_next, remaining;
  logic               row_edge, col_edge, row_in, col_in, legal;
  logic               do_push, do_pop;
  logic [PCKG_SZ-1:0] pkt, head_next;

  assign pkt = {8'h00, wr_row, wr_col, wr_mode, wr_payload};

  // Corners fail both edge tests because the other coordinate is out of the 1..N range.
  assign row_edge = (wr_row == 4'd0) || (wr_row == 4'(ROWS + 1));
  assign col_edge = (wr_col == 4'd0) || (wr_col == 4'(COLUMNS + 1));
  assign row_in   = (wr_row >= 4'd1) && (wr_row <= 4'(ROWS));
  assign col_in   = (wr_col >= 4'd1) && (wr_col <= 4'(COLUMNS));
  assign legal    = ({wr_row, wr_col} == BDCST) || (row_edge && col_in) || (col_edge && row_in);

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign count   = cnt;
  assign do_pop  = popin && pndng_i_in;
  assign do_push = wr_en && legal && (!full || do_pop);

  always_comb begin
    cnt_next = cnt;
    if (do_push && !do_pop)
      cnt_next = cnt + CW'(1);
    else if (do_pop && !do_push)
      cnt_next = cnt - CW'(1);
  end

  assign rd_ptr_next = do_pop ? rd_ptr + PW'(1) : rd_ptr;
  assign remaining   = cnt - CW'(do_pop);

  // When nothing older survives the edge, the incoming word is the next head (not yet in mem).
  assign head_next = (do_push && (remaining == '0)) ? pkt : mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      pndng_i_in    <= 1'b0;
      data_out_i_in <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_ptr_next;
      cnt        <= cnt_next;
      pndng_i_in <= (cnt_next != '0);
      if (cnt_next != '0)
        data_out_i_in <= head_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      illegal_cnt <= '0;
    end else if (clr_stat) begin
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      illegal_cnt <= '0;
    end else begin
      if (wr_en && !legal && (illegal_cnt != 16'hFFFF))
        illegal_cnt <= illegal_cnt + 16'd1;
      if (wr_en && legal && full && !do_pop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mesh_term_ingress.sv
// tb_mesh_term_ingress: directed self-checking bench for mesh_term_ingress.
`default_nettype none

module tb_mesh_term_ingress;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_row = '0;
  logic [3:0]  wr_col = '0;
  logic        wr_mode = 1'b0;
  logic [14:0] wr_payload = '0;
  logic        full;
  logic [4:0]  count;
  logic        pndng_i_in;
  logic [31:0] data_out_i_in;
  logic        popin = 1'b0;
  logic        clr_stat = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [15:0] illegal_cnt;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [16];

  mesh_term_ingress dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_mode(wr_mode), .wr_payload(wr_payload), .full(full), .count(count),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .clr_stat(clr_stat), .overflow(overflow), .drop_cnt(drop_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pkt(input logic [3:0] r, input logic [3:0] c,
                                          input logic m, input logic [14:0] p);
    return (32'(r) << 20) | (32'(c) << 16) | (32'(m) << 15) | 32'(p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [14:0] p);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_mode = m; wr_payload = p;
  endtask

  task automatic idle();
    wr_en = 1'b0; popin = 1'b0; clr_stat = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    total++; if (pndng_i_in !== 1'b0) $display("FAIL reset_pndng: got %b want 0", pndng_i_in); else passed++;
    total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
    total++; if (data_out_i_in !== 32'h0) $display("FAIL reset_data: got %h want 0", data_out_i_in); else passed++;
    total++; if ({overflow, drop_cnt, illegal_cnt} !== 33'h0)
      $display("FAIL reset_stats: got ovf=%b drop=%0d ill=%0d want 0", overflow, drop_cnt, illegal_cnt); else passed++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_wr(4'd0, 4'd2, 1'b0, 15'h1234);
    step();
    idle();
    total++; if (pndng_i_in !== 1'b1) $display("FAIL single_pndng: got %b want 1", pndng_i_in); else passed++;
    total++; if (data_out_i_in !== 32'h0002_1234) $display("FAIL single_data: got %h want 00021234", data_out_i_in); else passed++;
    total++; if (count !== 5'd1) $display("FAIL single_count: got %0d want 1", count); else passed++;
    step(); step();
    total++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h0002_1234)
      $display("FAIL single_hold: got pndng=%b data=%h want 1 00021234", pndng_i_in, data_out_i_in); else passed++;
    popin = 1'b1;
    step();
    idle();
    total++; if (pndng_i_in !== 1'b0 || count !== 5'd0)
      $display("FAIL single_pop: got pndng=%b count=%0d want 0 0", pndng_i_in, count); else passed++;
  endtask

  task automatic fill(input int base, input logic col_side);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] r, c;
      r = col_side ? 4'(i % 4 + 1) : 4'd0;
      c = col_side ? 4'd0 : 4'(i % 4 + 1);
      exp_q[i] = exp_pkt(r, c, logic'(i % 2), 15'(base + i * 3));
      set_wr(r, c, logic'(i % 2), 15'(base + i * 3));
      step();
    end
    idle();
  endtask

  task automatic test_fill_overflow();
    fill(5, 1'b0);
    total++; if (full !== 1'b1 || count !== 5'd16)
      $display("FAIL fill_full: got full=%b count=%0d want 1 16", full, count); else passed++;
    set_wr(4'd5, 4'd1, 1'b0, 15'h0777);
    step();
    idle();
    total++; if (drop_cnt !== 16'd1 || overflow !== 1'b1)
      $display("FAIL fill_drop: got drop=%0d ovf=%b want 1 1", drop_cnt, overflow); else passed++;
    total++; if (count !== 5'd16) $display("FAIL fill_count17: got %0d want 16", count); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (pndng_i_in !== 1'b1 || data_out_i_in !== exp_q[i])
        $display("FAIL fill_pop%0d: got pndng=%b data=%h want 1 %h", i, pndng_i_in, data_out_i_in, exp_q[i]); else passed++;
      popin = 1'b1;
      step();
    end
    idle();
    total++; if (pndng_i_in !== 1'b0 || count !== 5'd0 || full !== 1'b0)
      $display("FAIL fill_empty: got pndng=%b count=%0d full=%b want 0 0 0", pndng_i_in, count, full); else passed++;
  endtask

  task automatic test_full_push_pop();
    clr_stat = 1'b1;
    step();
    idle();
    total++; if (drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL clr_stats: got drop=%0d ovf=%b want 0 0", drop_cnt, overflow); else passed++;
    fill(100, 1'b1);
    set_wr(4'd5, 4'd3, 1'b1, 15'h7ABC);
    popin = 1'b1;
    step();
    idle();
    total++; if (count !== 5'd16 || full !== 1'b1)
      $display("FAIL pp_count: got count=%0d full=%b want 16 1", count, full); else passed++;
    total++; if (drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL pp_nodrop: got drop=%0d ovf=%b want 0 0", drop_cnt, overflow); else passed++;
    for (int i = 1; i < 17; i++) begin
      logic [31:0] e;
      e = (i == 16) ? exp_pkt(4'd5, 4'd3, 1'b1, 15'h7ABC) : exp_q[i];
      total++; if (pndng_i_in !== 1'b1 || data_out_i_in !== e)
        $display("FAIL pp_pop%0d: got pndng=%b data=%h want 1 %h", i, pndng_i_in, data_out_i_in, e); else passed++;
      popin = 1'b1;
      step();
    end
    idle();
    total++; if (pndng_i_in !== 1'b0) $display("FAIL pp_empty: got %b want 0", pndng_i_in); else passed++;
  endtask

  task automatic test_illegal();
    logic [7:0] bad [5];
    bad = '{8'h00, 8'h55, 8'h22, 8'h05, 8'h61};
    for (int i = 0; i < 5; i++) begin
      set_wr(bad[i][7:4], bad[i][3:0], 1'b0, 15'(i));
      step();
      total++; if (pndng_i_in !== 1'b0)
        $display("FAIL ill_pndng%0d: got %b want 0", i, pndng_i_in); else passed++;
    end
    idle();
    total++; if (illegal_cnt !== 16'd5 || count !== 5'd0)
      $display("FAIL ill_cnt: got ill=%0d count=%0d want 5 0", illegal_cnt, count); else passed++;
    set_wr(4'hF, 4'hF, 1'b1, 15'h0055);
    step();
    idle();
    total++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h00FF_8055)
      $display("FAIL bcast: got pndng=%b data=%h want 1 00ff8055", pndng_i_in, data_out_i_in); else passed++;
    set_wr(4'd2, 4'd2, 1'b0, 15'h0);
    clr_stat = 1'b1;
    popin = 1'b1;
    step();
    idle();
    total++; if (illegal_cnt !== 16'd0) $display("FAIL clr_wins: got %0d want 0", illegal_cnt); else passed++;
    total++; if (pndng_i_in !== 1'b0 || count !== 5'd0)
      $display("FAIL bcast_pop: got pndng=%b count=%0d want 0 0", pndng_i_in, count); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      set_wr(4'd5, 4'(i % 4 + 1), 1'b0, 15'(i + 40));
      step();
    end
    wr_en = 1'b0;
    popin = 1'b1;
    step();
    total++; if (count !== 5'd4) $display("FAIL ar_count4: got %0d want 4", count); else passed++;
    #3;
    reset = 1'b1;
    #1;
    total++; if (pndng_i_in !== 1'b0 || count !== 5'd0 || data_out_i_in !== 32'h0)
      $display("FAIL ar_clear: got pndng=%b count=%0d data=%h want 0 0 0", pndng_i_in, count, data_out_i_in); else passed++;
    #1;
    reset = 1'b0;
    idle();
    set_wr(4'd1, 4'd0, 1'b0, 15'h00AA);
    step();
    idle();
    total++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h0010_00AA || count !== 5'd1)
      $display("FAIL ar_first: got pndng=%b data=%h count=%0d want 1 001000aa 1", pndng_i_in, data_out_i_in, count); else passed++;
    popin = 1'b1;
    step();
    idle();
  endtask

  task automatic test_empty_pop();
    popin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (pndng_i_in !== 1'b0 || count !== 5'd0)
        $display("FAIL ep_idle%0d: got pndng=%b count=%0d want 0 0", i, pndng_i_in, count); else passed++;
    end
    set_wr(4'd0, 4'd3, 1'b1, 15'h0101);
    step();
    wr_en = 1'b0;
    total++; if (pndng_i_in !== 1'b1 || count !== 5'd1 || data_out_i_in !== 32'h0003_8101)
      $display("FAIL ep_push: got pndng=%b count=%0d data=%h want 1 1 00038101", pndng_i_in, count, data_out_i_in); else passed++;
    step();
    idle();
    total++; if (pndng_i_in !== 1'b0 || count !== 5'd0)
      $display("FAIL ep_pop: got pndng=%b count=%0d want 0 0", pndng_i_in, count); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_illegal();
    test_async_reset();
    test_empty_pop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
